control_riesgos: RTL and testbench
==================================

CONTROL_RIESGOS -- requirements
Module: control_riesgos

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: rs1, rs2  input  5 each  Decode-stage source register indices.
REQ-004 SHALL: rs1_used, rs2_used  input  1 each  Decode instruction actually reads rs1 / rs2.
REQ-005 SHALL: Branch_D, Taken_D  input  1 each  Decode holds a branch; branch comparator result (taken).
REQ-006 SHALL: rd_EXE, rd_MEM  input  5 each  destination index in EXE / MEM.
REQ-007 SHALL: RegWrite_EXE, MemRead_EXE, MemRead_MEM  input  1 each  EXE writes a register; EXE is a load; MEM is a load.
REQ-008 SHALL: Mem_Busy  input  1  data memory not ready; whole pipeline frozen.
REQ-009 SHALL: Stall_F, Stall_D  output  1 each  hold PC and the IF/ID register.
REQ-010 SHALL: Flush_E  output  1  insert a bubble into the ID/EXE register.
REQ-011 SHALL: Flush_D  output  1  squash the IF/ID register (taken branch).
REQ-012 SHALL: Stall_E, Stall_M  output  1 each  hold ID/EXE and EXE/MEM (memory wait only).
REQ-013 SHALL: Stall_Count, Flush_Count  output  16 each  performance counters (only when REQ-031 is enabled).

Function
REQ-014 SHALL: mE1 = rd_EXE!=0 and rd_EXE==rs1 and rs1_used; mE2, mM1, mM2 are defined the same way; mE = mE1|mE2; mM = mM1|mM2.
REQ-015 SHALL: need2 = Branch_D & MemRead_EXE & mE.
REQ-016 SHALL: need1 = !need2 & ((MemRead_EXE & mE & !Branch_D) | (Branch_D & RegWrite_EXE & !MemRead_EXE & mE) | (Branch_D & MemRead_MEM & mM)).
REQ-017 SHALL: FSM states RUN, STALL, WAIT.
REQ-018 SHALL: In RUN with Mem_Busy=0 and need1:
  - Stall_F = Stall_D = Flush_E = 1 in the same cycle (combinational).
  - Next state is RUN.
REQ-019 SHALL: In RUN with Mem_Busy=0 and need2:
  - Same outputs as REQ-018.
  - Next state is STALL with remaining count cnt=1.
REQ-020 SHALL: In STALL:
  - Stall_F = Stall_D = Flush_E = 1.
  - Hazard inputs are ignored.
  - cnt decrements each cycle; STALL returns to RUN when cnt reaches 0.
  - need2 therefore yields exactly 2 stall cycles in total.
REQ-021 SHALL: Flush_D = 1 only in RUN with Mem_Busy=0, Branch_D=1, Taken_D=1 and neither need1 nor need2 asserted.
REQ-022 SHALL: Mem_Busy=1 in any state:
  - Stall_F = Stall_D = Stall_E = Stall_M = 1.
  - Flush_E = Flush_D = 0.
  - Enter WAIT, saving the interrupted state and cnt.
  - WAIT resumes the saved state in the first cycle with Mem_Busy=0; cnt is not consumed while waiting.
REQ-023 SHALL: Stall_E = Stall_M = 0 whenever Mem_Busy=0.
REQ-024 SHALL: A taken branch detected while stalling is not flushed until the stall completes; it is re-evaluated in RUN.
REQ-025 SHALL: Register index 0 never creates a hazard.

Reset
REQ-026 SHALL: rst_n=0 forces RUN and cnt=0 asynchronously, including during an in-progress stall.
REQ-027 SHALL: While rst_n=0, all stall and flush outputs are 0.
REQ-028 SHALL: While rst_n=0, the counters are 0.
REQ-029 SHALL: After deassertion, the first rising edge evaluates the inputs as in RUN.

Configuration
REQ-030 SHALL: Macro RIESGOS_CONTADORES_EN selects the counter behaviour.
REQ-031 SHALL: With RIESGOS_CONTADORES_EN defined:
  - Stall_Count increments on every cycle with Stall_D=1 and Mem_Busy=0.
  - Flush_Count increments on every cycle with Flush_D=1.
  - Both counters saturate at 16'hFFFF.
REQ-032 SHALL: Without RIESGOS_CONTADORES_EN, both counter ports exist and are tied to 16'h0000, with no counter flops.

Verification
REQ-033 SHALL: Load-use, non-branch. Stimulus: MemRead_EXE=1, rd_EXE=5, rs1=5, rs1_used=1, Branch_D=0 for 1 cycle. Required: Stall_F/Stall_D/Flush_E high for exactly 1 cycle.
REQ-034 SHALL: Load feeding a branch. Stimulus: Branch_D=1, MemRead_EXE=1, rd_EXE=7, rs2=7, rs2_used=1. Required: 2 consecutive stall cycles, then Flush_D=1 if Taken_D=1.
REQ-035 SHALL: x0 ignored. Stimulus: rd_EXE=0, rs1=0, MemRead_EXE=1. Required: no stall, Flush_D=0 with Branch_D=0.
REQ-036 SHALL: Memory wait mid-stall. Stimulus: Mem_Busy=1 for 3 cycles during the second cycle of a need2 stall. Required: all four stall outputs high for 3 cycles, then exactly 1 further stall cycle.
REQ-037 SHALL: Reset mid-stall. Stimulus: rst_n=0 asynchronously during STALL. Required: outputs drop to 0 immediately; RUN after release.
REQ-038 SHALL: Counter saturation (RIESGOS_CONTADORES_EN defined). Stimulus: 65540 stall cycles. Required: Stall_Count=16'hFFFF; without the macro, Stall_Count=0.

Source files
------------

// File: rtl/control_riesgos.sv
// control_riesgos: pipeline hazard control unit.
// Detects load-use and branch-operand hazards in Decode, stalls IF/ID and
// bubbles ID/EXE, squashes IF/ID on a taken branch, and freezes the whole
// pipeline while data memory is busy.
// Optional performance counters are enabled with `define RIESGOS_CONTADORES_EN.
module control_riesgos (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic        rs1_used,
  input  logic        rs2_used,
  input  logic        Branch_D,
  input  logic        Taken_D,
  input  logic [4:0]  rd_EXE,
  input  logic [4:0]  rd_MEM,
  input  logic        RegWrite_EXE,
  input  logic        MemRead_EXE,
  input  logic        MemRead_MEM,
  input  logic        Mem_Busy,
  output logic        Stall_F,
  output logic        Stall_D,
  output logic        Flush_E,
  output logic        Flush_D,
  output logic        Stall_E,
  output logic        Stall_M,
  output logic [15:0] Stall_Count,
  output logic [15:0] Flush_Count
);

  typedef enum logic [1:0] {StRun, StStall, StWait} state_t;

  state_t     state_q, state_d;
  state_t     saved_state_q, saved_state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] saved_cnt_q, saved_cnt_d;

  // State as seen this cycle: WAIT behaves like the state it interrupted.
  state_t     eff_state;
  logic [1:0] eff_cnt;

  logic m_e1, m_e2, m_m1, m_m2, m_e, m_m;
  logic need1, need2;

  // Register-index matches; x0 never matches.
  assign m_e1 = (rd_EXE != 5'd0) && (rd_EXE == rs1) && rs1_used;
  assign m_e2 = (rd_EXE != 5'd0) && (rd_EXE == rs2) && rs2_used;
  assign m_m1 = (rd_MEM != 5'd0) && (rd_MEM == rs1) && rs1_used;
  assign m_m2 = (rd_MEM != 5'd0) && (rd_MEM == rs2) && rs2_used;
  assign m_e  = m_e1 | m_e2;
  assign m_m  = m_m1 | m_m2;

  // need2: branch waits on a load still in EXE (two bubbles).
  // need1: one bubble is enough.
  assign need2 = Branch_D & MemRead_EXE & m_e;
  assign need1 = ~need2 & ((MemRead_EXE & m_e & ~Branch_D) |
                           (Branch_D & RegWrite_EXE & ~MemRead_EXE & m_e) |
                           (Branch_D & MemRead_MEM & m_m));

  assign eff_state = (state_q == StWait) ? saved_state_q : state_q;
  assign eff_cnt   = (state_q == StWait) ? saved_cnt_q   : cnt_q;

  // State register with asynchronous reset back to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StRun;
      cnt_q         <= 2'd0;
      saved_state_q <= StRun;
      saved_cnt_q   <= 2'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      saved_state_q <= saved_state_d;
      saved_cnt_q   <= saved_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    saved_state_d = saved_state_q;
    saved_cnt_d   = saved_cnt_q;
    if (Mem_Busy) begin
      // Freeze: remember where we were; the remaining count is not consumed.
      state_d       = StWait;
      saved_state_d = eff_state;
      saved_cnt_d   = eff_cnt;
    end else begin
      unique case (eff_state)
        StRun: begin
          if (need2) begin
            state_d = StStall;
            cnt_d   = 2'd1;
          end else begin
            state_d = StRun;
            cnt_d   = 2'd0;
          end
        end
        StStall: begin
          if (eff_cnt <= 2'd1) begin
            state_d = StRun;
            cnt_d   = 2'd0;
          end else begin
            state_d = StStall;
            cnt_d   = eff_cnt - 2'd1;
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // Output decode; everything is forced low while reset is held.
  always_comb begin
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Flush_E = 1'b0;
    Flush_D = 1'b0;
    Stall_E = 1'b0;
    Stall_M = 1'b0;
    if (rst_n) begin
      if (Mem_Busy) begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Stall_E = 1'b1;
        Stall_M = 1'b1;
      end else begin
        unique case (eff_state)
          StRun: begin
            if (need1 || need2) begin
              Stall_F = 1'b1;
              Stall_D = 1'b1;
              Flush_E = 1'b1;
            end else if (Branch_D && Taken_D) begin
              Flush_D = 1'b1;
            end
          end
          StStall: begin
            // Hazard inputs and any taken branch wait until back in RUN.
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Flush_E = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef RIESGOS_CONTADORES_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Saturating performance counters; memory-wait cycles are not hazard stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      if (Stall_D && !Mem_Busy && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
      if (Flush_D && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign Stall_Count = stall_cnt_q;
  assign Flush_Count = flush_cnt_q;
`else
  assign Stall_Count = 16'h0000;
  assign Flush_Count = 16'h0000;
`endif

endmodule

// File: tb/tb_control_riesgos.sv
// Directed self-checking bench for control_riesgos.
module tb_control_riesgos;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd_EXE, rd_MEM;
  logic        rs1_used, rs2_used, Branch_D, Taken_D;
  logic        RegWrite_EXE, MemRead_EXE, MemRead_MEM, Mem_Busy;
  logic        Stall_F, Stall_D, Flush_E, Flush_D, Stall_E, Stall_M;
  logic [15:0] Stall_Count, Flush_Count;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef RIESGOS_CONTADORES_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  // Output vector order: {Stall_F, Stall_D, Flush_E, Flush_D, Stall_E, Stall_M}
  localparam logic [15:0] ONone = 16'b000000;
  localparam logic [15:0] OStl  = 16'b111000;
  localparam logic [15:0] OFld  = 16'b000100;
  localparam logic [15:0] OMem  = 16'b110011;

  logic [15:0] outs;
  assign outs = {10'd0, Stall_F, Stall_D, Flush_E, Flush_D, Stall_E, Stall_M};

  control_riesgos dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs1          (rs1),
    .rs2          (rs2),
    .rs1_used     (rs1_used),
    .rs2_used     (rs2_used),
    .Branch_D     (Branch_D),
    .Taken_D      (Taken_D),
    .rd_EXE       (rd_EXE),
    .rd_MEM       (rd_MEM),
    .RegWrite_EXE (RegWrite_EXE),
    .MemRead_EXE  (MemRead_EXE),
    .MemRead_MEM  (MemRead_MEM),
    .Mem_Busy     (Mem_Busy),
    .Stall_F      (Stall_F),
    .Stall_D      (Stall_D),
    .Flush_E      (Flush_E),
    .Flush_D      (Flush_D),
    .Stall_E      (Stall_E),
    .Stall_M      (Stall_M),
    .Stall_Count  (Stall_Count),
    .Flush_Count  (Flush_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
    Branch_D = 1'b0; Taken_D = 1'b0; rd_EXE = 5'd0; rd_MEM = 5'd0;
    RegWrite_EXE = 1'b0; MemRead_EXE = 1'b0; MemRead_MEM = 1'b0; Mem_Busy = 1'b0;
  endtask

  // Non-branch load-use on rs1 = x5 (need1).
  task automatic load_use();
    idle();
    MemRead_EXE = 1'b1; rd_EXE = 5'd5; rs1 = 5'd5; rs1_used = 1'b1;
  endtask

  // Branch reading x7 produced by a load in EXE (need2), taken.
  task automatic load_branch();
    idle();
    Branch_D = 1'b1; Taken_D = 1'b1; MemRead_EXE = 1'b1; rd_EXE = 5'd7;
    rs2 = 5'd7; rs2_used = 1'b1;
  endtask

  task automatic taken_branch();
    idle();
    Branch_D = 1'b1; Taken_D = 1'b1;
  endtask

  initial begin
    // Reset held with a hazard present: outputs and counters stay at zero.
    rst_n = 1'b0;
    load_use();
    #3;
    check("reset_outs", outs, ONone);
    check("reset_stall_cnt", Stall_Count, 16'h0000);
    check("reset_flush_cnt", Flush_Count, 16'h0000);

    // First cycle after release evaluates as RUN.
    @(negedge clk); rst_n = 1'b1; #1;
    check("loaduse_c1", outs, OStl);
    @(negedge clk); idle(); #1;
    check("loaduse_c2", outs, ONone);

    // x0 never hazards.
    @(negedge clk); idle(); MemRead_EXE = 1'b1; rs1_used = 1'b1; #1;
    check("x0_ignored", outs, ONone);

    // Unused operand does not hazard.
    @(negedge clk); load_use(); rs1_used = 1'b0; #1;
    check("rs1_unused", outs, ONone);

    // Load feeding a branch: two stalls, taken branch held back, then flush.
    @(negedge clk); load_branch(); #1;
    check("ldbr_c1", outs, OStl);
    @(negedge clk); taken_branch(); #1;
    check("ldbr_c2_ignores", outs, OStl);
    @(negedge clk); taken_branch(); #1;
    check("ldbr_flush", outs, OFld);
    @(negedge clk); idle(); #1;
    check("ldbr_after", outs, ONone);

    // Branch on ALU result in EXE: one stall.
    @(negedge clk); taken_branch(); RegWrite_EXE = 1'b1; rd_EXE = 5'd3;
    rs1 = 5'd3; rs1_used = 1'b1; #1;
    check("br_alu_exe", outs, OStl);
    // Branch on load in MEM: one stall.
    @(negedge clk); taken_branch(); MemRead_MEM = 1'b1; rd_MEM = 5'd4;
    rs2 = 5'd4; rs2_used = 1'b1; #1;
    check("br_load_mem", outs, OStl);
    // Not-taken branch, no hazard.
    @(negedge clk); taken_branch(); Taken_D = 1'b0; #1;
    check("br_not_taken", outs, ONone);

    // Memory busy in RUN overrides hazards and flushes.
    @(negedge clk); load_branch(); Mem_Busy = 1'b1; #1;
    check("busy_run", outs, OMem);
    @(negedge clk); idle(); #1;
    check("busy_run_resume", outs, ONone);

    // Memory wait during the second stall cycle: 3 frozen, then 1 more stall.
    @(negedge clk); load_branch(); #1;
    check("midstall_c1", outs, OStl);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); idle(); Mem_Busy = 1'b1; #1;
      check($sformatf("midstall_busy%0d", i), outs, OMem);
    end
    @(negedge clk); idle(); #1;
    check("midstall_resume", outs, OStl);
    @(negedge clk); idle(); #1;
    check("midstall_done", outs, ONone);

    // Asynchronous reset in STALL.
    @(negedge clk); load_branch(); #1;
    check("rst_stall_c1", outs, OStl);
    @(negedge clk); idle(); #1;
    check("rst_stall_c2", outs, OStl);
    #1 rst_n = 1'b0; #1;
    check("rst_stall_drop", outs, ONone);
    @(negedge clk); rst_n = 1'b1; taken_branch(); #1;
    check("rst_stall_run", outs, OFld);

    // Counters: 3 hazard stalls, 1 busy cycle (not counted), 2 flushes.
    @(negedge clk); idle(); rst_n = 1'b0; #1;
    check("cnt_clear", Stall_Count, 16'h0000);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); load_use();
    repeat (3) @(negedge clk);
    load_use(); Mem_Busy = 1'b1;
    @(negedge clk); taken_branch(); #1;
    check("cnt_busy_resume", outs, OFld);
    @(negedge clk); taken_branch();
    @(negedge clk); idle(); #1;
    check("stall_count", Stall_Count, CntEn ? 16'd3 : 16'd0);
    check("flush_count", Flush_Count, CntEn ? 16'd2 : 16'd0);

    // Saturation.
    @(negedge clk); load_use();
    repeat (65540) @(negedge clk);
    idle(); #1;
    check("stall_count_sat", Stall_Count, CntEn ? 16'hFFFF : 16'h0000);
    check("flush_count_hold", Flush_Count, CntEn ? 16'd2 : 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
